// File: rtl/seg_scan_pkg.sv
// Shared types and sizing helpers for the seven-segment digit scanner.
package seg_scan_pkg;

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_e;

    // Counter width able to hold the longer of the two phase lengths.
    function automatic int unsigned cnt_width(input int unsigned dwell, input int unsigned blank);
        int unsigned longest;
        longest = (dwell > blank) ? dwell : blank;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/seg_dwell_timer.sv
// Phase timer: counts up while enabled, flags the terminal count, clears on request.
module seg_dwell_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             tc_c
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc_c = en && (count == limit);

endmodule

// File: rtl/seg_digit_scanner.sv
// Time-multiplexed seven-segment digit scanner: digit storage, blank/show FSM,
// leading-zero suppression and registered anode/segment-enable outputs.
module seg_digit_scanner
    import seg_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned DWELL_CYCLES  = 1000,
    parameter int unsigned BLANK_CYCLES  = 16,
    parameter bit          ANODE_ACT_LOW = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
    input  logic [3:0]                    wr_data,
    input  logic                          lz_en,
    output logic [3:0]                    digit_val,
    output logic                          seg_en,
    output logic [NUM_DIGITS-1:0]         anode,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned CNT_W = cnt_width(DWELL_CYCLES, BLANK_CYCLES);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ANODE_ACT_LOW}};

    logic [3:0]            digits [NUM_DIGITS];
    logic                  wr_ok;
    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_d;
    logic [CNT_W-1:0]      limit;
    logic                  tc;
    logic [NUM_DIGITS-1:0] supp;
    logic                  zero_run;
    logic [NUM_DIGITS-1:0] anode_d;
    logic                  seg_en_d;

    assign wr_ok = {1'b0, wr_addr} < (IDX_W + 1)'(NUM_DIGITS);

    // Digit register file; writes are accepted regardless of ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                digits[i] <= 4'h0;
            end
        end else if (wr_en && wr_ok) begin
            digits[wr_addr] <= wr_data;
        end
    end

    assign limit = (state_q == ST_SHOW) ? CNT_W'(DWELL_CYCLES - 1) : CNT_W'(BLANK_CYCLES - 1);

    seg_dwell_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ena),
        .clr   (tc),
        .limit (limit),
        .tc_c  (tc)
    );

    // A digit is blanked when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        supp     = '0;
        zero_run = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zero_run = zero_run & (digits[i] == 4'h0);
            supp[i]  = lz_en & zero_run & (i != 0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_BLANK;
            digit_idx <= '0;
        end else begin
            state_q   <= state_d;
            digit_idx <= idx_d;
        end
    end

    // Next state plus next-cycle outputs, aligned with the state being entered.
    always_comb begin
        state_d  = state_q;
        idx_d    = digit_idx;
        anode_d  = ANODE_OFF;
        seg_en_d = 1'b0;
        if (tc) begin
            if (state_q == ST_BLANK) begin
                state_d = ST_SHOW;
            end else begin
                state_d = ST_BLANK;
                idx_d   = (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
            end
        end
        if (ena && (state_d == ST_SHOW)) begin
            anode_d  = (NUM_DIGITS'(1) << idx_d) ^ ANODE_OFF;
            seg_en_d = ~supp[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_val <= 4'h0;
            seg_en    <= 1'b0;
            anode     <= ANODE_OFF;
        end else begin
            digit_val <= digits[idx_d];
            seg_en    <= seg_en_d;
            anode     <= anode_d;
        end
    end

endmodule

// File: tb/tb_seg_digit_scanner.sv
// Self-checking bench for seg_digit_scanner against a frame-position reference model.
module tb_seg_digit_scanner;

    localparam int ND    = 4;
    localparam int DW    = 8;
    localparam int BL    = 2;
    localparam int SLOT  = DW + BL;
    localparam int FRAME = ND * SLOT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = 2'd0;
    logic [3:0] wr_data = 4'h0;
    logic       lz_en = 1'b0;
    logic [3:0] digit_val;
    logic       seg_en;
    logic [3:0] anode;
    logic [1:0] digit_idx;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: t counts enabled clock edges since reset.
    int          t = 0;
    logic [3:0]  m_dig [ND];
    logic [10:0] exp_vec;

    seg_digit_scanner #(
        .NUM_DIGITS    (ND),
        .DWELL_CYCLES  (DW),
        .BLANK_CYCLES  (BL),
        .ANODE_ACT_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .lz_en     (lz_en),
        .digit_val (digit_val),
        .seg_en    (seg_en),
        .anode     (anode),
        .digit_idx (digit_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] observed();
        return {anode, seg_en, digit_val, digit_idx};
    endfunction

    task automatic model_reset();
        t = 0;
        for (int i = 0; i < ND; i++) m_dig[i] = 4'h0;
        exp_vec = {4'hF, 1'b0, 4'h0, 2'd0};
    endtask

    // One clock edge: predict outputs from pre-edge digits and inputs, then apply the write.
    task automatic tick();
        int  k;
        bit  show;
        bit  supp;
        logic [3:0] an;
        @(posedge clk);
        if (ena) t++;
        k    = (t / SLOT) % ND;
        show = ena && ((t % SLOT) >= BL);
        supp = lz_en && (k != 0);
        for (int j = k; j < ND; j++) if (m_dig[j] != 4'h0) supp = 1'b0;
        an = 4'hF;
        if (show) an[k] = 1'b0;
        exp_vec = {an, show && !supp, m_dig[k], 2'(k)};
        if (wr_en) m_dig[wr_addr] = wr_data;
        #1;
    endtask

    task automatic write_digit(input int addr, input logic [3:0] val);
        wr_en   = 1'b1;
        wr_addr = 2'(addr);
        wr_data = val;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (observed() !== {4'hF, 1'b0, 4'h0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_values: got %h want %h", observed(), {4'hF, 1'b0, 4'h0, 2'd0});
        end
        model_reset();
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_scan();
        int cnt_d0 = 0;
        int cnt_off = 0;
        ena = 1'b1;
        for (int i = 0; i < ND; i++) begin
            write_digit(i, 4'(i + 1));
            n_tests++;
            if (observed() !== exp_vec) begin
                n_fail++;
                $display("FAIL scan_write%0d: got %h want %h", i, observed(), exp_vec);
            end
        end
        for (int c = 0; c < 2 * FRAME; c++) begin
            tick();
            if (anode == 4'b1110) cnt_d0++;
            if (anode == 4'b1111) cnt_off++;
            n_tests++;
            if (observed() !== exp_vec) begin
                n_fail++;
                $display("FAIL scan t=%0d: got %h want %h", t, observed(), exp_vec);
            end
        end
        n_tests++;
        if (cnt_d0 != 2 * DW || cnt_off != 2 * ND * BL) begin
            n_fail++;
            $display("FAIL scan_counts: d0=%0d off=%0d want %0d %0d", cnt_d0, cnt_off, 2 * DW, 2 * ND * BL);
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 2 * FRAME && !((t % FRAME) == 2 * SLOT + 5); c++) tick();
        n_tests++;
        if ((t % FRAME) != 2 * SLOT + 5 || anode !== 4'b1011) begin
            n_fail++;
            $display("FAIL rstmid_setup: t=%0d anode=%b want 1011", t, anode);
        end
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({anode, seg_en, digit_val, digit_idx} !== {4'hF, 1'b0, 4'h0, 2'd0}) begin
            n_fail++;
            $display("FAIL rstmid_async: got %h want %h", observed(), {4'hF, 1'b0, 4'h0, 2'd0});
        end
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_tests++;
            if (observed() !== exp_vec) begin
                n_fail++;
                $display("FAIL rstmid_resume%0d: got %h want %h", c, observed(), exp_vec);
            end
        end
        n_tests++;
        if (anode !== 4'b1110) begin
            n_fail++;
            $display("FAIL rstmid_first_digit: anode=%b want 1110", anode);
        end
    endtask

    task automatic test_lz();
        logic [3:0] mask;
        lz_en = 1'b1;
        write_digit(0, 4'h0);
        write_digit(1, 4'h0);
        write_digit(2, 4'h5);
        write_digit(3, 4'h0);
        for (int pass = 0; pass < 2; pass++) begin
            mask = 4'h0;
            for (int c = 0; c < FRAME; c++) begin
                tick();
                if (anode != 4'hF && seg_en) mask[digit_idx] = 1'b1;
                n_tests++;
                if (observed() !== exp_vec) begin
                    n_fail++;
                    $display("FAIL lz%0d t=%0d: got %h want %h", pass, t, observed(), exp_vec);
                end
            end
            n_tests++;
            if (mask !== (pass == 0 ? 4'b0111 : 4'b0001)) begin
                n_fail++;
                $display("FAIL lz_mask%0d: got %b want %b", pass, mask, (pass == 0 ? 4'b0111 : 4'b0001));
            end
            write_digit(2, 4'h0);
        end
        lz_en = 1'b0;
    endtask

    task automatic test_write_show();
        int cnt = 0;
        for (int i = 0; i < ND; i++) write_digit(i, 4'(i + 1));
        for (int c = 0; c < 2 * FRAME && (t % FRAME) != SLOT + 1; c++) tick();
        for (int c = 0; c < SLOT - 1; c++) begin
            if (c == 2) begin
                wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'h9;
            end
            tick();
            wr_en = 1'b0;
            if (anode == 4'b1101) cnt++;
            if (c == 3) begin
                n_tests++;
                if (digit_val !== 4'h9) begin
                    n_fail++;
                    $display("FAIL wr_show_val: got %h want 9", digit_val);
                end
            end
            n_tests++;
            if (observed() !== exp_vec) begin
                n_fail++;
                $display("FAIL wr_show t=%0d: got %h want %h", t, observed(), exp_vec);
            end
        end
        tick();
        n_tests++;
        if (cnt != DW || anode !== 4'hF) begin
            n_fail++;
            $display("FAIL wr_show_dwell: cycles=%0d anode=%b want %0d 1111", cnt, anode, DW);
        end
    endtask

    task automatic test_pause();
        int cnt = 0;
        for (int c = 0; c < 2 * FRAME && (t % FRAME) != 1; c++) tick();
        for (int c = 0; c < 4; c++) begin
            tick();
            if (anode == 4'b1110) cnt++;
        end
        ena = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_tests++;
            if (anode !== 4'hF || seg_en !== 1'b0 || observed() !== exp_vec) begin
                n_fail++;
                $display("FAIL pause%0d: got %h want %h", c, observed(), exp_vec);
            end
        end
        ena = 1'b1;
        for (int c = 0; c < 20 && (t % FRAME) != SLOT; c++) begin
            tick();
            if (anode == 4'b1110) cnt++;
            n_tests++;
            if (observed() !== exp_vec) begin
                n_fail++;
                $display("FAIL pause_resume t=%0d: got %h want %h", t, observed(), exp_vec);
            end
        end
        n_tests++;
        if (cnt != DW) begin
            n_fail++;
            $display("FAIL pause_dwell: got %0d want %0d", cnt, DW);
        end
    endtask

    task automatic test_wrap_write();
        for (int c = 0; c < 2 * FRAME && (t % FRAME) != FRAME - 1; c++) tick();
        wr_en = 1'b1; wr_addr = 2'd3; wr_data = 4'hA;
        tick();
        wr_en = 1'b0;
        n_tests++;
        if (digit_idx !== 2'd0 || anode !== 4'hF) begin
            n_fail++;
            $display("FAIL wrap_idx: idx=%0d anode=%b want 0 1111", digit_idx, anode);
        end
        for (int c = 0; c < FRAME && (t % FRAME) != 3 * SLOT + BL; c++) begin
            tick();
            n_tests++;
            if (observed() !== exp_vec) begin
                n_fail++;
                $display("FAIL wrap t=%0d: got %h want %h", t, observed(), exp_vec);
            end
        end
        n_tests++;
        if (anode !== 4'b0111 || digit_val !== 4'hA) begin
            n_fail++;
            $display("FAIL wrap_newval: anode=%b val=%h want 0111 a", anode, digit_val);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            ena     = ($urandom_range(0, 9) != 0);
            wr_en   = ($urandom_range(0, 7) == 0);
            wr_addr = 2'($urandom_range(0, 3));
            wr_data = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            if (c % 50 == 0) lz_en = 1'($urandom);
            tick();
            n_tests++;
            if (observed() !== exp_vec) begin
                n_fail++;
                $display("FAIL random t=%0d: got %h want %h", t, observed(), exp_vec);
            end
        end
        wr_en = 1'b0;
        ena   = 1'b1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_scan();
        test_reset_mid();
        test_lz();
        test_write_show();
        test_pause();
        test_wrap_write();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
